// File: rtl/relay_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : relay_pkg
//  Description : Shared definitions for the address-bus arbiter.
//                - state_t : transaction phase encoding (IDLE/SETUP/STROBE/HOLD)
//                - REQ_*   : requester index constants
//                - CNT_W   : width of the phase counter
//  Revision    : 1.0 - initial release
// ============================================================================
package relay_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      HOLD   = 2'd3
   } state_t;

   localparam int REQ_PC = 0;
   localparam int REQ_M  = 1;
   localparam int REQ_J  = 2;
   localparam int REQ_XY = 3;

   localparam int CNT_W  = 4;

endpackage : relay_pkg
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick4
//  Description : Combinational four-way round-robin picker. Priority starts
//                at (last + 1) mod 4 and wraps 3 -> 0.
//  Ports       : req   [3:0] in  - request vector
//                last  [1:0] in  - index granted most recently
//                valid       out - at least one request present
//                idx   [1:0] out - winning requester index
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick4
   import relay_pkg::*;
(
   input  logic [3:0] req,
   input  logic [1:0] last,
   output logic       valid,
   output logic [1:0] idx
);

   logic [1:0] w_cand;

   // Walk from lowest to highest priority so the highest-priority active
   // requester is the last one written.
   always_comb begin
      valid  = 1'b0;
      idx    = last;
      w_cand = '0;
      for (int k = 3; k >= 0; k--) begin
         w_cand = last + 2'(k) + 2'd1;
         if (req[w_cand]) begin
            valid = 1'b1;
            idx   = w_cand;
         end
      end
   end

endmodule : rr_pick4
`default_nettype wire

// File: rtl/addr_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : addr_bus_arbiter
//  Description : Round-robin arbiter for the shared address bus. One owner at
//                a time runs SETUP -> STROBE -> HOLD, then the bus returns to
//                IDLE for at least one cycle before the next grant.
//  Parameters  : SETUP_CYC  (1-15) select-to-strobe cycles
//                STROBE_CYC (1-15) mem_rd/mem_wr width
//                HOLD_CYC   (1-15) select hold after strobe
//  Ports       : clk, reset (sync, active high)
//                req[3:0], wr[3:0]          requests / write flags (0=PC,1=M,2=J,3=XY)
//                gnt[3:0], done[3:0]        one-hot grant / completion pulse
//                sel_pc, sel_m, sel_j, sel_xy  address register drive enables
//                mem_rd, mem_wr             memory strobes
//                busy                       any state other than IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module addr_bus_arbiter
   import relay_pkg::*;
#(
   parameter int SETUP_CYC  = 1,
   parameter int STROBE_CYC = 2,
   parameter int HOLD_CYC   = 1
)(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] req,
   input  logic [3:0] wr,
   output logic [3:0] gnt,
   output logic [3:0] done,
   output logic       sel_pc,
   output logic       sel_m,
   output logic       sel_j,
   output logic       sel_xy,
   output logic       mem_rd,
   output logic       mem_wr,
   output logic       busy
);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_last;   // last granted index; also the current owner
   logic             r_wr;     // write flag latched at grant
   logic [3:0]       r_gnt;
   logic [3:0]       r_done;
   logic             r_rd;
   logic             r_wrs;

   logic             w_valid;
   logic [1:0]       w_idx;

   rr_pick4 u_pick (
      .req   (req),
      .last  (r_last),
      .valid (w_valid),
      .idx   (w_idx)
   );

   // Outputs are registered one cycle ahead of the state they describe, so
   // each transition also loads the output values for the state it enters.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_last  <= 2'd3;
         r_wr    <= 1'b0;
         r_gnt   <= '0;
         r_done  <= '0;
         r_rd    <= 1'b0;
         r_wrs   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_valid) begin
                  r_state <= SETUP;
                  r_cnt   <= CNT_W'(SETUP_CYC);
                  r_last  <= w_idx;
                  r_wr    <= wr[w_idx];
                  r_gnt   <= 4'b0001 << w_idx;
               end
            end
            SETUP: begin
               if (r_cnt == 4'd1) begin
                  r_state <= STROBE;
                  r_cnt   <= CNT_W'(STROBE_CYC);
                  r_rd    <= ~r_wr;
                  r_wrs   <= r_wr;
               end else begin
                  r_cnt   <= r_cnt - 4'd1;
               end
            end
            STROBE: begin
               if (r_cnt == 4'd1) begin
                  r_state <= HOLD;
                  r_cnt   <= CNT_W'(HOLD_CYC);
                  r_rd    <= 1'b0;
                  r_wrs   <= 1'b0;
                  // A one-cycle HOLD is its own last cycle.
                  r_done  <= (HOLD_CYC == 1) ? r_gnt : 4'b0000;
               end else begin
                  r_cnt   <= r_cnt - 4'd1;
               end
            end
            HOLD: begin
               if (r_cnt == 4'd1) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
                  r_gnt   <= '0;
                  r_done  <= '0;
               end else begin
                  r_cnt   <= r_cnt - 4'd1;
                  r_done  <= (r_cnt == 4'd2) ? r_gnt : 4'b0000;
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
               r_gnt   <= '0;
               r_done  <= '0;
               r_rd    <= 1'b0;
               r_wrs   <= 1'b0;
            end
         endcase
      end
   end

   assign gnt    = r_gnt;
   assign done   = r_done;
   assign sel_pc = r_gnt[REQ_PC];
   assign sel_m  = r_gnt[REQ_M];
   assign sel_j  = r_gnt[REQ_J];
   assign sel_xy = r_gnt[REQ_XY];
   assign mem_rd = r_rd;
   assign mem_wr = r_wrs;
   assign busy   = (r_state != IDLE);

endmodule : addr_bus_arbiter
`default_nettype wire

// File: tb/tb_addr_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_addr_bus_arbiter
//  Description : Self-checking bench. The main instance uses default timing
//                and is tracked by a transaction-level model (owner, age
//                since grant, round-robin pointer). A second instance with
//                SETUP=3/STROBE=1/HOLD=2 is checked against fixed waveforms.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_addr_bus_arbiter;

   localparam int S   = 1;
   localparam int T   = 2;
   localparam int H   = 1;
   localparam int TOT = S + T + H;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // main instance
   logic       reset = 1'b1;
   logic [3:0] req   = '0;
   logic [3:0] wr    = '0;
   logic [3:0] gnt, done;
   logic       sel_pc, sel_m, sel_j, sel_xy, mem_rd, mem_wr, busy;

   // alternate-timing instance
   logic       reset2 = 1'b1;
   logic [3:0] req2   = '0;
   logic [3:0] wr2    = '0;
   logic [3:0] gnt2, done2;
   logic       sel_pc2, sel_m2, sel_j2, sel_xy2, mem_rd2, mem_wr2, busy2;

   addr_bus_arbiter #(.SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H)) u_dut (
      .clk(clk), .reset(reset), .req(req), .wr(wr), .gnt(gnt), .done(done),
      .sel_pc(sel_pc), .sel_m(sel_m), .sel_j(sel_j), .sel_xy(sel_xy),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .busy(busy)
   );

   addr_bus_arbiter #(.SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(2)) u_dut2 (
      .clk(clk), .reset(reset2), .req(req2), .wr(wr2), .gnt(gnt2), .done(done2),
      .sel_pc(sel_pc2), .sel_m(sel_m2), .sel_j(sel_j2), .sel_xy(sel_xy2),
      .mem_rd(mem_rd2), .mem_wr(mem_wr2), .busy(busy2)
   );

   // {gnt, done, sel_xy/j/m/pc, mem_rd, mem_wr, busy}
   wire [14:0] obs  = {gnt, done, sel_xy, sel_j, sel_m, sel_pc, mem_rd, mem_wr, busy};
   wire [14:0] obs2 = {gnt2, done2, sel_xy2, sel_j2, sel_m2, sel_pc2, mem_rd2, mem_wr2, busy2};

   int checks   = 0;
   int failures = 0;

   // Transaction-level reference model
   logic m_active = 1'b0;
   int   m_age    = 0;    // cycles since grant, 1..TOT
   int   m_owner  = 0;
   logic m_wr     = 1'b0;
   int   m_last   = 3;

   function automatic logic [14:0] model_out();
      logic [3:0] g;
      logic       strobe;
      if (!m_active) return '0;
      g      = 4'b0001 << m_owner;
      strobe = (m_age > S) && (m_age <= S + T);
      return {g, (m_age == TOT) ? g : 4'b0000, g, strobe && !m_wr, strobe && m_wr, 1'b1};
   endfunction

   function automatic logic [14:0] pack_exp(input logic [3:0] g, input logic [3:0] d,
                                            input logic rd, input logic wrs, input logic b);
      return {g, d, g, rd, wrs, b};
   endfunction

   // Drive one cycle's inputs, advance to the next cycle, update the model.
   task automatic tick(input logic [3:0] r, input logic [3:0] w, input logic rst);
      logic found;
      int   c;
      req   = r;
      wr    = w;
      reset = rst;
      @(posedge clk);
      if (rst) begin
         m_active = 1'b0;
         m_last   = 3;
      end else if (m_active) begin
         m_age++;
         if (m_age > TOT) m_active = 1'b0;
      end else begin
         found = 1'b0;
         for (int k = 1; k <= 4; k++) begin
            c = (m_last + k) % 4;
            if (!found && r[c]) begin
               found    = 1'b1;
               m_owner  = c;
               m_wr     = w[c];
               m_last   = c;
               m_active = 1'b1;
               m_age    = 1;
            end
         end
      end
      #1;
   endtask

   task automatic test_reset();
      tick(4'hF, 4'hF, 1'b1);
      tick(4'hF, 4'h0, 1'b1);
      checks++;
      if (obs !== 15'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%h want=%h", obs, 15'd0);
      end
      checks++;
      if (obs2 !== 15'd0) begin
         failures++;
         $display("FAIL reset_outputs2 got=%h want=%h", obs2, 15'd0);
      end
   endtask

   task automatic test_basic_read();
      logic [14:0] e;
      tick(4'h0, 4'h0, 1'b1);
      tick(4'b0010, 4'b0000, 1'b0);   // cycle 0 -> cycle 1
      for (int c = 1; c <= 5; c++) begin
         e = pack_exp((c <= 4) ? 4'b0010 : 4'b0000, (c == 4) ? 4'b0010 : 4'b0000,
                      (c == 2 || c == 3), 1'b0, (c <= 4));
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL basic_read cycle=%0d got=%h want=%h", c, obs, e);
         end
         checks++;
         if (obs !== model_out()) begin
            failures++;
            $display("FAIL basic_read_model cycle=%0d got=%h want=%h", c, obs, model_out());
         end
         tick(4'h0, 4'h0, 1'b0);
      end
   endtask

   task automatic test_round_robin();
      int          order[$];
      logic [3:0]  prev;
      int          idx;
      tick(4'h0, 4'h0, 1'b1);
      prev = '0;
      for (int c = 1; c <= 26; c++) begin
         tick(4'hF, 4'h0, 1'b0);
         checks++;
         if (obs !== model_out()) begin
            failures++;
            $display("FAIL rr_model cycle=%0d got=%h want=%h", c, obs, model_out());
         end
         if (gnt != 4'b0000 && prev != 4'b0000 && gnt != prev) begin
            checks++;
            failures++;
            $display("FAIL rr_gap cycle=%0d got=%b after=%b want_idle_between", c, gnt, prev);
         end
         if (gnt != 4'b0000 && prev == 4'b0000) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (gnt[i]) idx = i;
            order.push_back(idx);
         end
         prev = gnt;
      end
      checks++;
      if (order.size() < 5) begin
         failures++;
         $display("FAIL rr_count got=%0d want_at_least=5", order.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (order[i] != (i % 4)) begin
               failures++;
               $display("FAIL rr_order slot=%0d got=%0d want=%0d", i, order[i], i % 4);
            end
         end
      end
   endtask

   task automatic test_wr_latch();
      tick(4'h0, 4'h0, 1'b1);
      tick(4'b0100, 4'b0100, 1'b0);   // cycle 1: SETUP
      tick(4'b0100, 4'b0100, 1'b0);   // cycle 2: STROBE
      for (int c = 2; c <= 5; c++) begin
         checks++;
         if (mem_wr !== (c == 2 || c == 3) || mem_rd !== 1'b0) begin
            failures++;
            $display("FAIL wr_latch cycle=%0d got_wr=%b got_rd=%b want_wr=%b want_rd=0",
                     c, mem_wr, mem_rd, (c == 2 || c == 3));
         end
         checks++;
         if (obs !== model_out()) begin
            failures++;
            $display("FAIL wr_latch_model cycle=%0d got=%h want=%h", c, obs, model_out());
         end
         tick(4'h0, 4'h0, 1'b0);      // wr dropped during STROBE
      end
   endtask

   task automatic test_reset_abort();
      tick(4'h0, 4'h0, 1'b1);
      tick(4'b0010, 4'h0, 1'b0);      // cycle 1 SETUP
      tick(4'b0010, 4'h0, 1'b0);      // cycle 2 STROBE
      checks++;
      if (mem_rd !== 1'b1) begin
         failures++;
         $display("FAIL abort_precheck got_rd=%b want=1", mem_rd);
      end
      tick(4'hF, 4'hF, 1'b1);         // reset wins over requests
      checks++;
      if (obs !== 15'd0) begin
         failures++;
         $display("FAIL abort_outputs got=%h want=%h", obs, 15'd0);
      end
      tick(4'b1000, 4'h0, 1'b0);
      checks++;
      if (gnt !== 4'b1000 || sel_xy !== 1'b1 || done !== 4'b0000) begin
         failures++;
         $display("FAIL abort_regrant got_gnt=%b got_done=%b want_gnt=1000 want_done=0000", gnt, done);
      end
      for (int c = 0; c < 5; c++) tick(4'h0, 4'h0, 1'b0);
      tick(4'h0, 4'h0, 1'b1);
      tick(4'b1001, 4'h0, 1'b0);
      checks++;
      if (gnt !== 4'b0001 || obs !== model_out()) begin
         failures++;
         $display("FAIL reset_pointer got=%b want=0001", gnt);
      end
   endtask

   task automatic test_params();
      logic [14:0] e;
      reset  = 1'b1;
      req    = '0;
      reset2 = 1'b1;
      @(posedge clk);
      #1;
      m_active = 1'b0;
      m_last   = 3;
      reset2   = 1'b0;
      req2     = 4'b0001;
      wr2      = 4'b0000;
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk);
         #1;
         req2 = 4'b0000;
         e = pack_exp((c <= 6) ? 4'b0001 : 4'b0000, (c == 6) ? 4'b0001 : 4'b0000,
                      (c == 4), 1'b0, (c <= 6));
         checks++;
         if (obs2 !== e) begin
            failures++;
            $display("FAIL param_timing cycle=%0d got=%h want=%h", c, obs2, e);
         end
      end
   endtask

   task automatic test_random();
      logic [3:0] r, w;
      logic       rst;
      tick(4'h0, 4'h0, 1'b1);
      for (int c = 0; c < 500; c++) begin
         r   = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
         w   = 4'($urandom_range(0, 15));
         rst = ($urandom_range(0, 63) == 0);
         tick(r, w, rst);
         checks++;
         if (obs !== model_out()) begin
            failures++;
            $display("FAIL random cycle=%0d got=%h want=%h", c, obs, model_out());
         end
         checks++;
         if (!$onehot0({sel_xy, sel_j, sel_m, sel_pc}) || (mem_rd && mem_wr) || !$onehot0(gnt)) begin
            failures++;
            $display("FAIL exclusivity cycle=%0d got=%h want=onehot0", c, obs);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_read();
      test_round_robin();
      test_wr_latch();
      test_reset_abort();
      test_params();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_addr_bus_arbiter
`default_nettype wire

// File: doc/addr_bus_arbiter.md
ADDR_BUS_ARBITER -- requirements
Module: addr_bus_arbiter

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 1: cycles a source select is held before the memory strobe (range 1-15).
REQ-002 SHALL have parameter STROBE_CYC, default 2: cycles mem_rd/mem_wr are asserted (range 1-15).
REQ-003 SHALL have parameter HOLD_CYC, default 1: cycles the select is held after the strobe (range 1-15).
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req  in  4  per-requester address-bus request; index 0=PC, 1=M (M1:M2), 2=J (J1:J2), 3=XY.
REQ-007 wr  in  4  per-requester write flag; sampled only at grant; 1 = memory write, 0 = memory read.
REQ-008 gnt  out  4  one-hot grant to the owning requester.
REQ-009 done  out  4  one-cycle completion pulse to the owning requester.
REQ-010 sel_pc, sel_m, sel_j, sel_xy  out  1 each  drive enables to the address-bus registers; sel_m drives both selM1 and selM2.
REQ-011 mem_rd, mem_wr  out  1 each  memory strobes.
REQ-012 busy  out  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, SETUP, STROBE, HOLD; transitions IDLE->SETUP (any req), SETUP->STROBE, STROBE->HOLD, HOLD->IDLE, each after its parameter's cycle count.
REQ-014 SHALL use a 4-bit phase counter, loaded at each state entry and decremented each cycle; transition when the counter reaches 1.
REQ-015 SHALL arbitrate in IDLE only, round-robin: priority starts at (last granted index + 1) mod 4 and wraps 3->0.
REQ-016 SHALL register the winner index and its wr bit at the IDLE->SETUP edge; both are fixed until return to IDLE.
REQ-017 SHALL assert gnt[winner] and exactly one sel_* (matching winner) in SETUP, STROBE and HOLD, and none in IDLE.
REQ-018 SHALL assert mem_rd (latched wr=0) or mem_wr (latched wr=1) only in STROBE; never both.
REQ-019 SHALL pulse done[winner] for exactly the last HOLD cycle.
REQ-020 Latency: req high in IDLE at cycle t -> gnt and sel at t+1; done at t+SETUP_CYC+STROBE_CYC+HOLD_CYC.
REQ-021 SHALL spend at least one IDLE cycle between transactions (bus-release gap), so selects of different sources never overlap or abut.
REQ-022 Deassertion of req mid-transaction SHALL NOT abort it; the transaction completes and done still pulses.
REQ-023 Changes of req/wr outside IDLE SHALL be ignored.
REQ-024 A requester still holding req after its done SHALL be eligible again only in round-robin order.
REQ-025 With no req in IDLE, the FSM SHALL remain in IDLE with all outputs 0 and the pointer unchanged.

Reset
REQ-026 reset high at a rising edge SHALL force IDLE, phase counter 0, last-granted pointer 3 (so requester 0 has top priority), and all outputs 0 from the next cycle, including mid-transaction; no done pulse is issued for an aborted transaction.
REQ-027 reset SHALL take precedence over every other input.

Structure
REQ-028 Shared package relay_pkg SHALL hold the state enum (IDLE, SETUP, STROBE, HOLD), the requester index constants (REQ_PC=0, REQ_M=1, REQ_J=2, REQ_XY=3) and the counter width constant (4).
REQ-029 The round-robin picker SHALL be a separate combinational sub-module rr_pick4 (inputs req[4], last[2]; outputs valid, idx[2]); the arbiter holds the FSM, counter and latches.

Verification
REQ-030 Default parameters, req=0010, wr=0000 at cycle 0 -> gnt=0010 and sel_m=1 cycles 1-4, mem_rd=1 cycles 2-3, done[1] in cycle 4, busy low in cycle 5.
REQ-031 req=1111 held after reset -> grant order 0,1,2,3,0 with one IDLE cycle between transactions.
REQ-032 req=0100, wr=0100 at grant, wr dropped to 0 in STROBE -> mem_wr stays high both STROBE cycles, mem_rd never asserts.
REQ-033 reset asserted during STROBE -> next cycle all outputs 0, no done; then req=1000 -> requester 3 granted; with req=1001 -> requester 0 granted.
REQ-034 SETUP_CYC=3, STROBE_CYC=1, HOLD_CYC=2, req=0001 at cycle 0 -> sel_pc cycles 1-6, mem_rd cycle 4 only, done[0] cycle 6.
REQ-035 Assertion check throughout: at most one sel_* high, mem_rd & mem_wr never both high, gnt one-hot or zero.
